// File: rtl/morra_pkg.sv
// morra_pkg: shared encodings and FSM state type for the MorraCinese tournament sequencer.
//  Move codes: 00 invalid, 01/10/11 legal moves (legality is judged by the core).
//  MANCHE/PARTITA codes: 00 none, 01 player 1, 10 player 2, 11 draw.
package morra_pkg;

    localparam logic [1:0] MOVE_INVALID = 2'b00;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // Idle value on the core's PRIMO/SECONDO inputs: an uncounted manche.
    localparam logic [1:0] NOP = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_COLLECT,
        ST_ISSUE,
        ST_RESULT,
        ST_TALLY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/morra_torneo_ctrl_if.sv
// morra_torneo_ctrl_if: player move handshakes and the MorraCinese core link.
//  pN_valid/pN_move/pN_ready   player N move offer and acceptance
//  core_primo/core_secondo     moves (or match config) toward the core
//  core_inizia                 core start-of-match strobe
//  core_manche/core_partita    round and match results from the core
//  master: the sequencer side; slave: players plus core side.
interface morra_torneo_ctrl_if;

    logic       p1_valid;
    logic [1:0] p1_move;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_move;
    logic       p2_ready;
    logic [1:0] core_primo;
    logic [1:0] core_secondo;
    logic       core_inizia;
    logic [1:0] core_manche;
    logic [1:0] core_partita;

    modport master (
        input  p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita,
        output p1_ready, p2_ready, core_primo, core_secondo, core_inizia
    );

    modport slave (
        output p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita,
        input  p1_ready, p2_ready, core_primo, core_secondo, core_inizia
    );

endinterface

// File: rtl/morra_move_latch.sv
// morra_move_latch: single-entry move capture register for one player.
//  clk, rst_n   clock, synchronous active-low reset
//  en           capture window open (sequencer collecting moves)
//  clr          empty the latch
//  valid, move  player offer
//  ready        latch open and empty; a move is taken when valid && ready
//  full, move_q latch occupancy and stored move
module morra_move_latch
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       valid,
    input  logic [1:0] move,
    output logic       ready,
    output logic       full,
    output logic [1:0] move_q
);

    logic       full_q, full_d;
    logic [1:0] mv_q, mv_d;
    logic       take;

    assign ready  = en && !full_q;
    assign take   = valid && ready;
    assign full   = full_q;
    assign move_q = mv_q;

    always_comb begin
        full_d = clr ? 1'b0 : (take ? 1'b1 : full_q);
        mv_d   = clr ? MOVE_INVALID : (take ? move : mv_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            mv_q   <= MOVE_INVALID;
        end else begin
            full_q <= full_d;
            mv_q   <= mv_d;
        end
    end

endmodule

// File: rtl/morra_torneo_ctrl.sv
// morra_torneo_ctrl: best-of-N tournament sequencer driving a MorraCinese core.
//  clk, rst_n    clock, synchronous active-low reset
//  bus           player handshakes and core link (master side)
//  start         begin a tournament (ignored while busy)
//  cfg_max       match config, driven as {PRIMO,SECONDO} with INIZIA
//  busy          tournament in progress
//  torneo_done   one-cycle pulse when the tournament is decided
//  vincitore     01 P1, 10 P2, 11 draw; held until the next start
//  wins1, wins2  match wins per player
//  manche_cnt    counted manche in the current match (saturates at 31)
//  timeout_err   one-cycle pulse when move collection times out
module morra_torneo_ctrl
    import morra_pkg::*;
#(
    parameter int N_PARTITE   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    morra_torneo_ctrl_if.master bus,
    input  logic                start,
    input  logic [3:0]          cfg_max,
    output logic                busy,
    output logic                torneo_done,
    output logic [1:0]          vincitore,
    output logic [3:0]          wins1,
    output logic [3:0]          wins2,
    output logic [4:0]          manche_cnt,
    output logic                timeout_err
);

    localparam logic [3:0] WIN_TH = 4'(N_PARTITE / 2 + 1);
    localparam logic [3:0] N_M    = 4'(N_PARTITE);
    localparam int         TW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [3:0]    wins1_q, wins1_d, wins2_q, wins2_d, mcnt_q, mcnt_d;
    logic [4:0]    manche_q, manche_d;
    logic [1:0]    vinc_q, vinc_d, res_q, res_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    primo, secondo, m1, m2;
    logic          inizia, lclr, busy_o, done_o, tmo_o;
    logic          r1, r2, f1, f2, have1, have2, fin;
    logic [3:0]    w1_inc, w2_inc, mcnt_inc;

    morra_move_latch u_p1 (
        .clk(clk), .rst_n(rst_n), .en(state_q == ST_COLLECT), .clr(lclr),
        .valid(bus.p1_valid), .move(bus.p1_move), .ready(r1), .full(f1), .move_q(m1)
    );

    morra_move_latch u_p2 (
        .clk(clk), .rst_n(rst_n), .en(state_q == ST_COLLECT), .clr(lclr),
        .valid(bus.p2_valid), .move(bus.p2_move), .ready(r2), .full(f2), .move_q(m2)
    );

    // A move arriving this cycle counts as present, so it beats a same-cycle timeout.
    assign have1 = f1 || (bus.p1_valid && r1);
    assign have2 = f2 || (bus.p2_valid && r2);

    assign w1_inc   = wins1_q + {3'b0, res_q == RES_P1};
    assign w2_inc   = wins2_q + {3'b0, res_q == RES_P2};
    assign mcnt_inc = mcnt_q + 4'd1;
    assign fin      = w1_inc >= WIN_TH || w2_inc >= WIN_TH || mcnt_inc == N_M;

    always_comb begin
        state_d  = state_q;
        wins1_d  = wins1_q;
        wins2_d  = wins2_q;
        mcnt_d   = mcnt_q;
        manche_d = manche_q;
        vinc_d   = vinc_q;
        res_d    = res_q;
        tcnt_d   = tcnt_q;
        primo    = NOP;
        secondo  = NOP;
        inizia   = 1'b0;
        lclr     = 1'b0;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        tmo_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start) begin
                    state_d = ST_CONFIG;
                    wins1_d = '0;
                    wins2_d = '0;
                    mcnt_d  = '0;
                    vinc_d  = '0;
                end
            end
            ST_CONFIG: begin
                inizia            = 1'b1;
                {primo, secondo}  = cfg_max;
                manche_d          = '0;
                lclr              = 1'b1;
                tcnt_d            = '0;
                state_d           = ST_COLLECT;
            end
            ST_COLLECT: begin
                tcnt_d = tcnt_q + TW'(1);
                if (have1 && have2) begin
                    state_d = ST_ISSUE;
                end else if (tcnt_q == T_LAST) begin
                    // The player who did show up takes the match; nobody showing is a draw.
                    tmo_o   = 1'b1;
                    res_d   = have1 ? RES_P1 : (have2 ? RES_P2 : RES_DRAW);
                    state_d = ST_TALLY;
                end
            end
            ST_ISSUE: begin
                primo   = m1;
                secondo = m2;
                lclr    = 1'b1;
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                manche_d = (bus.core_manche != RES_NONE && manche_q != 5'd31) ? manche_q + 5'd1 : manche_q;
                tcnt_d   = '0;
                res_d    = bus.core_partita;
                state_d  = (bus.core_partita == RES_NONE) ? ST_COLLECT : ST_TALLY;
            end
            ST_TALLY: begin
                wins1_d = w1_inc;
                wins2_d = w2_inc;
                mcnt_d  = mcnt_inc;
                vinc_d  = fin ? ((w1_inc > w2_inc) ? RES_P1 : (w2_inc > w1_inc) ? RES_P2 : RES_DRAW) : vinc_q;
                state_d = fin ? ST_DONE : ST_CONFIG;
            end
            ST_DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wins1_q  <= '0;
            wins2_q  <= '0;
            mcnt_q   <= '0;
            manche_q <= '0;
            vinc_q   <= '0;
            res_q    <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wins1_q  <= wins1_d;
            wins2_q  <= wins2_d;
            mcnt_q   <= mcnt_d;
            manche_q <= manche_d;
            vinc_q   <= vinc_d;
            res_q    <= res_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.p1_ready     = r1;
    assign bus.p2_ready     = r2;
    assign bus.core_primo   = primo;
    assign bus.core_secondo = secondo;
    assign bus.core_inizia  = inizia;
    assign busy             = busy_o;
    assign torneo_done      = done_o;
    assign timeout_err      = tmo_o;
    assign vincitore        = vinc_q;
    assign wins1            = wins1_q;
    assign wins2            = wins2_q;
    assign manche_cnt       = manche_q;

endmodule

// File: tb/tb_morra_torneo_ctrl.sv
// tb_morra_torneo_ctrl: randomized tournaments against a match-level reference model.
module tb_morra_torneo_ctrl;

    localparam int NP  = 3;
    localparam int TMO = 12;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic [3:0] cfg_max = 0;
    logic       busy, torneo_done, timeout_err;
    logic [1:0] vincitore;
    logic [3:0] wins1, wins2;
    logic [4:0] manche_cnt;

    int total = 0;
    int bad = 0;

    int         exp_w1, exp_w2, exp_mc;
    logic [4:0] exp_manche = 0;
    logic [1:0] exp_vinc = 0;

    int         pk[8];
    int         pn[8];
    int         pd[8];
    logic [1:0] pr[8];
    logic [1:0] po[8];

    morra_torneo_ctrl_if bus();

    morra_torneo_ctrl #(.N_PARTITE(NP), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master), .start(start), .cfg_max(cfg_max),
        .busy(busy), .torneo_done(torneo_done), .vincitore(vincitore), .wins1(wins1),
        .wins2(wins2), .manche_cnt(manche_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        bus.core_manche = 2'b00;
        bus.core_partita = 2'b00;
    endtask

    task automatic set_plan(input int i, input int k, input logic [1:0] r, input int n, input int d,
                            input logic [1:0] o);
        pk[i] = k; pr[i] = r; pn[i] = n; pd[i] = d; po[i] = o;
    endtask

    task automatic run_round(input logic [1:0] mv1, input logic [1:0] mv2, input int d1, input int d2,
                             input bit hold, input logic [1:0] man, input logic [1:0] par);
        bit g1, g2;
        int c;
        g1 = 0; g2 = 0; c = 0;
        while (!(g1 && g2) && c < TMO + 2) begin
            tick;
            bus.p1_valid = c >= d1 && (!g1 || hold);
            bus.p1_move = g1 ? 2'($urandom) : mv1;
            bus.p2_valid = c >= d2 && (!g2 || hold);
            bus.p2_move = g2 ? 2'($urandom) : mv2;
            start = $urandom_range(0, 3) == 0;
            #1;
            total++;
            if (bus.core_inizia !== 1'b0 || bus.core_primo !== 2'b00 || bus.core_secondo !== 2'b00 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL collect_nop: inizia=%b primo=%b secondo=%b tmo=%b required 0/00/00/0",
                         bus.core_inizia, bus.core_primo, bus.core_secondo, timeout_err);
            end
            total++;
            if (bus.p1_ready !== !g1 || bus.p2_ready !== !g2) begin
                bad++;
                $display("FAIL collect_ready: ready=%b%b required %b%b", bus.p1_ready, bus.p2_ready, !g1, !g2);
            end
            total++;
            if (manche_cnt !== exp_manche) begin
                bad++;
                $display("FAIL collect_manche: got %0d required %0d", manche_cnt, exp_manche);
            end
            if (bus.p1_valid && bus.p1_ready) g1 = 1;
            if (bus.p2_valid && bus.p2_ready) g2 = 1;
            c++;
        end
        start = 0;
        tick;
        bus.p1_valid = 0;
        bus.p2_valid = 0;
        #1;
        total++;
        if (!(g1 && g2) || bus.core_primo !== mv1 || bus.core_secondo !== mv2 || bus.core_inizia !== 1'b0 ||
            bus.p1_ready !== 1'b0 || bus.p2_ready !== 1'b0) begin
            bad++;
            $display("FAIL issue: captured=%b%b primo=%b secondo=%b inizia=%b required moves %b %b inizia 0",
                     g1, g2, bus.core_primo, bus.core_secondo, bus.core_inizia, mv1, mv2);
        end
        tick;
        bus.core_manche = man;
        bus.core_partita = par;
        #1;
        total++;
        if (bus.core_inizia !== 1'b0 || bus.core_primo !== 2'b00 || bus.core_secondo !== 2'b00) begin
            bad++;
            $display("FAIL result_nop: inizia=%b primo=%b secondo=%b required 0/00/00",
                     bus.core_inizia, bus.core_primo, bus.core_secondo);
        end
        if (man != 2'b00 && exp_manche != 5'd31) exp_manche++;
    endtask

    task automatic run_timeout_round(input logic [1:0] off);
        bit g1, g2;
        g1 = 0; g2 = 0;
        for (int c = 0; c < TMO; c++) begin
            tick;
            bus.p1_valid = off[0] && !g1;
            bus.p1_move = 2'($urandom);
            bus.p2_valid = off[1] && !g2;
            bus.p2_move = 2'($urandom);
            #1;
            total++;
            if (timeout_err !== (c == TMO - 1)) begin
                bad++;
                $display("FAIL timeout_pulse: cycle %0d got %b required %b", c + 1, timeout_err, c == TMO - 1);
            end
            if (bus.p1_valid && bus.p1_ready) g1 = 1;
            if (bus.p2_valid && bus.p2_ready) g2 = 1;
        end
        bus.p1_valid = 0;
        bus.p2_valid = 0;
    endtask

    task automatic run_tournament(input int n, input logic [3:0] cfg);
        bit decided;
        logic [1:0] res;
        cfg_max = cfg;
        start = 1;
        tick;
        start = 0;
        #1;
        total++;
        if (bus.core_inizia !== 1'b1 || {bus.core_primo, bus.core_secondo} !== cfg || busy !== 1'b1 ||
            wins1 !== 4'd0 || wins2 !== 4'd0 || vincitore !== 2'b00 || torneo_done !== 1'b0) begin
            bad++;
            $display("FAIL config: inizia=%b cfg=%b busy=%b wins=%0d/%0d vinc=%b required 1 %b 1 0/0 00",
                     bus.core_inizia, {bus.core_primo, bus.core_secondo}, busy, wins1, wins2, vincitore, cfg);
        end
        exp_w1 = 0; exp_w2 = 0; exp_mc = 0; decided = 0;
        for (int i = 0; i < n && !decided; i++) begin
            exp_manche = 0;
            case (pk[i])
                1: begin
                    run_timeout_round(po[i]);
                    res = (po[i] == 2'b00) ? 2'b11 : po[i];
                end
                2: begin
                    run_round(2'($urandom), 2'($urandom), 0, pd[i], 1, 2'($urandom), pr[i]);
                    res = pr[i];
                end
                default: begin
                    for (int r = 0; r < pn[i]; r++)
                        run_round(2'($urandom), 2'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                                  1'($urandom), 2'($urandom), (r == pn[i] - 1) ? pr[i] : 2'b00);
                    res = pr[i];
                end
            endcase
            tick;
            #1;
            total++;
            if (busy !== 1'b1 || manche_cnt !== exp_manche || bus.core_inizia !== 1'b0 || bus.core_primo !== 2'b00 ||
                bus.core_secondo !== 2'b00 || timeout_err !== 1'b0 || torneo_done !== 1'b0) begin
                bad++;
                $display("FAIL tally: busy=%b manche=%0d inizia=%b tmo=%b done=%b required 1 %0d 0 0 0",
                         busy, manche_cnt, bus.core_inizia, timeout_err, torneo_done, exp_manche);
            end
            exp_w1 += (res == 2'b01) ? 1 : 0;
            exp_w2 += (res == 2'b10) ? 1 : 0;
            exp_mc++;
            decided = exp_w1 >= NP / 2 + 1 || exp_w2 >= NP / 2 + 1 || exp_mc == NP;
            tick;
            #1;
            total++;
            if (decided) begin
                exp_vinc = (exp_w1 > exp_w2) ? 2'b01 : (exp_w2 > exp_w1) ? 2'b10 : 2'b11;
                if (torneo_done !== 1'b1 || busy !== 1'b0 || vincitore !== exp_vinc ||
                    wins1 !== 4'(exp_w1) || wins2 !== 4'(exp_w2) || bus.core_inizia !== 1'b0) begin
                    bad++;
                    $display("FAIL done: done=%b busy=%b vinc=%b wins=%0d/%0d inizia=%b required 1 0 %b %0d/%0d 0",
                             torneo_done, busy, vincitore, wins1, wins2, bus.core_inizia, exp_vinc, exp_w1, exp_w2);
                end
            end else if (bus.core_inizia !== 1'b1 || {bus.core_primo, bus.core_secondo} !== cfg || busy !== 1'b1 ||
                         wins1 !== 4'(exp_w1) || wins2 !== 4'(exp_w2) || torneo_done !== 1'b0) begin
                bad++;
                $display("FAIL next_config: inizia=%b cfg=%b busy=%b wins=%0d/%0d done=%b required 1 %b 1 %0d/%0d 0",
                         bus.core_inizia, {bus.core_primo, bus.core_secondo}, busy, wins1, wins2, torneo_done,
                         cfg, exp_w1, exp_w2);
            end
        end
        if (!decided) begin
            bad++;
            $display("FAIL plan_exhausted: tournament undecided after %0d matches", n);
        end
        tick;
        #1;
        total++;
        if (torneo_done !== 1'b0 || busy !== 1'b0 || vincitore !== exp_vinc || bus.core_inizia !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: done=%b busy=%b vinc=%b inizia=%b required 0 0 %b 0",
                     torneo_done, busy, vincitore, bus.core_inizia, exp_vinc);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick;
        tick;
        #1;
        total++;
        if (busy !== 1'b0 || torneo_done !== 1'b0 || vincitore !== 2'b00 || wins1 !== 4'd0 || wins2 !== 4'd0 ||
            manche_cnt !== 5'd0 || timeout_err !== 1'b0 || bus.core_inizia !== 1'b0 || bus.core_primo !== 2'b00 ||
            bus.core_secondo !== 2'b00 || bus.p1_ready !== 1'b0 || bus.p2_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b vinc=%b wins=%0d/%0d manche=%0d tmo=%b inizia=%b primo=%b secondo=%b required all 0",
                     busy, torneo_done, vincitore, wins1, wins2, manche_cnt, timeout_err,
                     bus.core_inizia, bus.core_primo, bus.core_secondo);
        end
        rst_n = 1;
        tick;
        #1;
    endtask

    task automatic test_two_wins;
        set_plan(0, 0, 2'b01, 4, 0, 2'b00);
        set_plan(1, 0, 2'b01, 2, 0, 2'b00);
        set_plan(2, 0, 2'b10, 1, 0, 2'b00);
        run_tournament(3, 4'b1001);
    endtask

    task automatic test_draw_split;
        set_plan(0, 0, 2'b11, 1, 0, 2'b00);
        set_plan(1, 0, 2'b01, 1, 0, 2'b00);
        set_plan(2, 0, 2'b10, 1, 0, 2'b00);
        run_tournament(3, 4'b0110);
    endtask

    task automatic test_slow_p2;
        set_plan(0, 2, 2'b10, 1, 10, 2'b00);
        set_plan(1, 2, 2'b10, 1, TMO - 1, 2'b00);
        run_tournament(2, 4'b1111);
    endtask

    task automatic test_timeout;
        set_plan(0, 1, 2'b00, 1, 0, 2'b01);
        set_plan(1, 1, 2'b00, 1, 0, 2'b00);
        set_plan(2, 1, 2'b00, 1, 0, 2'b10);
        run_tournament(3, 4'b0011);
    endtask

    task automatic test_reset_mid;
        cfg_max = 4'b0110;
        start = 1;
        tick;
        start = 0;
        tick;
        bus.p1_valid = 1;
        bus.p1_move = 2'b01;
        bus.p2_valid = 1;
        bus.p2_move = 2'b10;
        tick;
        bus.p1_valid = 0;
        bus.p2_valid = 0;
        tick;
        bus.core_manche = 2'b01;
        bus.core_partita = 2'b01;
        rst_n = 0;
        tick;
        #1;
        total++;
        if (busy !== 1'b0 || torneo_done !== 1'b0 || vincitore !== 2'b00 || wins1 !== 4'd0 || wins2 !== 4'd0 ||
            manche_cnt !== 5'd0 || bus.core_inizia !== 1'b0 || bus.core_primo !== 2'b00 || bus.core_secondo !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b vinc=%b wins=%0d/%0d manche=%0d inizia=%b primo=%b secondo=%b required all 0",
                     busy, torneo_done, vincitore, wins1, wins2, manche_cnt,
                     bus.core_inizia, bus.core_primo, bus.core_secondo);
        end
        rst_n = 1;
        exp_vinc = 2'b00;
        tick;
        #1;
        set_plan(0, 0, 2'b10, 2, 0, 2'b00);
        set_plan(1, 0, 2'b01, 1, 0, 2'b00);
        set_plan(2, 0, 2'b01, 3, 0, 2'b00);
        run_tournament(3, 4'b1001);
    endtask

    task automatic test_random;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 4) == 0)
                    set_plan(i, 1, 2'b00, 1, 0, 2'($urandom_range(0, 2)));
                else
                    set_plan(i, 0, 2'($urandom_range(1, 3)), $urandom_range(1, 4), 0, 2'b00);
            end
            run_tournament(NP, 4'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.p1_valid = 0;
        bus.p1_move = 0;
        bus.p2_valid = 0;
        bus.p2_move = 0;
        bus.core_manche = 0;
        bus.core_partita = 0;
        test_reset;
        test_two_wins;
        test_draw_split;
        test_slow_p2;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
